instr_sequencer: RTL and testbench

//  Control-path sequencer directly upstream of the instruction decoder. It owns the

---
 rtl/instr_sequencer.sv | 69 ++++++
 tb/tb_instr_sequencer.sv | 125 ++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer: FETCH/EXEC1/EXEC2/HALT control sequencer with instruction register,
// jump flag and retired-instruction counter.
module instr_sequencer #(
  parameter int          CNT_W    = 16,
  parameter logic [15:0] IR_RESET = 16'h0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_en,
  input  logic [15:0]      instr_rdata,
  input  logic             sm_extra,
  input  logic             stop,
  input  logic             set_jump,
  output logic [15:0]      instruction,
  output logic [1:0]       state,
  output logic             jump,
  output logic             halted,
  output logic             retire,
  output logic [CNT_W-1:0] retired_count
);
  typedef enum logic [1:0] {FETCH = 2'b00, EXEC1 = 2'b01, EXEC2 = 2'b10, HALT = 2'b11} state_e;

  state_e             state_q, state_d;
  logic [15:0]        ir_q, ir_d;
  logic               jump_q, jump_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      ir_q    <= IR_RESET;
      jump_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      jump_q  <= jump_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    jump_d  = set_jump ? 1'b1 : (state_q == EXEC1 ? 1'b0 : jump_q);
    retire  = !stop && ((state_q == EXEC1 && !sm_extra) || state_q == EXEC2);
    if (state_q == HALT) begin
      jump_d = jump_q;
      retire = 1'b0;
    end else if (stop) begin
      state_d = HALT;
      jump_d  = 1'b0;
    end else begin
      case (state_q)
        FETCH:   state_d = run_en ? EXEC1 : FETCH;
        EXEC1:   state_d = sm_extra ? EXEC2 : FETCH;
        default: state_d = FETCH;
      endcase
      ir_d = (state_q == FETCH && run_en) ? instr_rdata : ir_q;
    end
    cnt_d = cnt_q + CNT_W'(retire);
  end

  assign instruction   = ir_q;
  assign state         = state_q;
  assign jump          = jump_q;
  assign halted        = (state_q == HALT);
  assign retired_count = cnt_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: randomized run of two sequencers (16-bit and 4-bit counters) against
// an instruction-level reference model, including async resets and halts.
module tb_instr_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        run_en, sm_extra, stop, set_jump;
  logic [15:0] instr_rdata;
  logic [15:0] instr_a, instr_b;
  logic [1:0]  state_a, state_b;
  logic        jump_a, jump_b, halted_a, halted_b, retire_a, retire_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  int total = 0;
  int bad   = 0;

  // reference model: phase 0 fetch, 1 first exec, 2 second exec, 3 halted
  int          m_phase;
  logic [15:0] m_ir;
  bit          m_jump;
  int          m_retired;

  always #5 clk = ~clk;

  instr_sequencer u_a (
    .clk(clk), .rst_n(rst_n), .run_en(run_en), .instr_rdata(instr_rdata),
    .sm_extra(sm_extra), .stop(stop), .set_jump(set_jump),
    .instruction(instr_a), .state(state_a), .jump(jump_a), .halted(halted_a),
    .retire(retire_a), .retired_count(cnt_a)
  );

  instr_sequencer #(.CNT_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .run_en(run_en), .instr_rdata(instr_rdata),
    .sm_extra(sm_extra), .stop(stop), .set_jump(set_jump),
    .instruction(instr_b), .state(state_b), .jump(jump_b), .halted(halted_b),
    .retire(retire_b), .retired_count(cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_retire();
    return !stop && ((m_phase == 1 && !sm_extra) || m_phase == 2);
  endfunction

  task automatic check_regs();
    chk("state",     32'(state_a),  32'(m_phase));
    chk("state4",    32'(state_b),  32'(m_phase));
    chk("instr",     32'(instr_a),  32'(m_ir));
    chk("instr4",    32'(instr_b),  32'(m_ir));
    chk("jump",      32'(jump_a),   32'(m_jump));
    chk("jump4",     32'(jump_b),   32'(m_jump));
    chk("halted",    32'(halted_a), 32'(m_phase == 3));
    chk("halted4",   32'(halted_b), 32'(m_phase == 3));
    chk("count16",   32'(cnt_a),    32'(m_retired % 65536));
    chk("count4",    32'(cnt_b),    32'(m_retired % 16));
  endtask

  task automatic model_reset();
    m_phase = 0; m_ir = 16'h0000; m_jump = 0; m_retired = 0;
  endtask

  task automatic model_step();
    bit ret;
    ret = m_retire();
    if (m_phase == 3) return;
    if (stop) begin
      m_phase = 3;
      m_jump  = 0;
      return;
    end
    m_jump = set_jump ? 1'b1 : (m_phase == 1 ? 1'b0 : m_jump);
    if (m_phase == 0) begin
      if (run_en) begin
        m_phase = 1;
        m_ir    = instr_rdata;
      end
    end else if (m_phase == 1) m_phase = sm_extra ? 2 : 0;
    else m_phase = 0;
    if (ret) m_retired++;
  endtask

  task automatic randomize_inputs();
    run_en      = ($urandom_range(9) < 7);
    sm_extra    = ($urandom_range(9) < 4);
    set_jump    = ($urandom_range(9) < 3);
    stop        = ($urandom_range(59) == 0);
    instr_rdata = 16'($urandom);
  endtask

  initial begin
    rst_n = 1'b0;
    run_en = 0; sm_extra = 0; stop = 0; set_jump = 0; instr_rdata = 16'h0;
    model_reset();
    repeat (2) @(posedge clk);
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst_n = 1'b1;
      check_regs();
      if ($urandom_range(m_phase == 3 ? 19 : 299) == 0) begin
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_regs();
        randomize_inputs();
        @(posedge clk);
        continue;
      end
      randomize_inputs();
      #1;
      chk("retire",  32'(retire_a), 32'(m_retire()));
      chk("retire4", 32'(retire_b), 32'(m_retire()));
      @(posedge clk);
      model_step();
    end
    @(negedge clk);
    check_regs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
